frequency_analyzer_sequencer: RTL and testbench

FREQUENCY_ANALYZER_SEQUENCER -- requirements
Module: frequency_analyzer_sequencer

---
 rtl/frequency_analyzer_sequencer.sv | 145 ++++++++++++++
 tb/tb_frequency_analyzer_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frequency_analyzer_sequencer.sv
// Measurement sequencer for a two-channel frequency analyzer: clears the
// analyzer, gates it for a fixed window, waits for the counts to settle,
// captures them, classifies the dominant channel and presents the result
// through a valid/ready handshake with a sticky overrun flag.
module frequency_analyzer_sequencer #(
  parameter int unsigned WINDOW_CYCLES = 50000,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned MIN_COUNT     = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        continuous,
  input  logic        abort,
  input  logic [31:0] f0_count,
  input  logic [31:0] f1_count,
  output logic        analyzer_enable,
  output logic        analyzer_clear,
  output logic [31:0] f0_result,
  output logic [31:0] f1_result,
  output logic [1:0]  dominant,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    MEASURE,
    SETTLE,
    CAPTURE
  } state_t;

  localparam logic [31:0] WIN_LAST = WINDOW_CYCLES - 1;
  localparam logic [7:0]  SET_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [31:0] MIN_CNT  = MIN_COUNT;

  state_t      state;
  state_t      state_next;
  logic [31:0] win_cnt;
  logic [7:0]  set_cnt;
  logic        capture_fire;

  // Dominance: strictly larger channel wins if it reaches the floor; ties give none.
  function automatic logic [1:0] classify(input logic [31:0] a, input logic [31:0] b);
    logic [1:0] d;
    d = 2'b00;
    if ((a > b) && (a >= MIN_CNT)) begin
      d = 2'b01;
    end else if ((b > a) && (b >= MIN_CNT)) begin
      d = 2'b10;
    end
    return d;
  endfunction

  assign busy         = (state != IDLE);
  assign capture_fire = (state == CAPTURE) && !abort;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and analyzer control; abort overrides every transition.
  always_comb begin
    state_next      = state;
    analyzer_enable = 1'b0;
    analyzer_clear  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        analyzer_clear = 1'b1;
        state_next     = MEASURE;
      end
      MEASURE: begin
        analyzer_enable = 1'b1;
        if (win_cnt == WIN_LAST) begin
          state_next = (SETTLE_CYCLES == 0) ? CAPTURE : SETTLE;
        end
      end
      SETTLE: begin
        if (set_cnt == SET_LAST) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        state_next = continuous ? CLEAR : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (abort) begin
      state_next = IDLE;
    end
  end

  // Window and settle counters run only inside their own state and restart from zero otherwise.
  always_ff @(posedge clock) begin
    if (!reset) begin
      win_cnt <= '0;
      set_cnt <= '0;
    end else begin
      win_cnt <= ((state == MEASURE) && !abort) ? win_cnt + 32'd1 : '0;
      set_cnt <= ((state == SETTLE) && !abort) ? set_cnt + 8'd1 : '0;
    end
  end

  // Result capture, handshake and sticky overrun; abort freezes all of them.
  always_ff @(posedge clock) begin
    if (!reset) begin
      f0_result    <= '0;
      f1_result    <= '0;
      dominant     <= 2'b00;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (!abort) begin
      if (capture_fire) begin
        f0_result    <= f0_count;
        f1_result    <= f1_count;
        dominant     <= classify(f0_count, f1_count);
        result_valid <= 1'b1;
        if (result_valid && !result_ready) begin
          overrun <= 1'b1;
        end
      end else if (result_valid && result_ready) begin
        result_valid <= 1'b0;
      end
      if ((state == IDLE) && start) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frequency_analyzer_sequencer.sv
// Bench for frequency_analyzer_sequencer: directed scenarios with literal
// expectations plus a timeline-based reference model compared every cycle.
module tb_frequency_analyzer_sequencer;

  localparam int W   = 100;
  localparam int S   = 2;
  localparam int MC  = 1;
  localparam int CAP = W + S + 2;

  logic        clock;
  logic        reset;
  logic        start;
  logic        continuous;
  logic        abort;
  logic [31:0] f0_count;
  logic [31:0] f1_count;
  logic        analyzer_enable;
  logic        analyzer_clear;
  logic [31:0] f0_result;
  logic [31:0] f1_result;
  logic [1:0]  dominant;
  logic        result_valid;
  logic        result_ready;
  logic        busy;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;

  frequency_analyzer_sequencer #(
    .WINDOW_CYCLES(W),
    .SETTLE_CYCLES(S),
    .MIN_COUNT(MC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .continuous(continuous),
    .abort(abort),
    .f0_count(f0_count),
    .f1_count(f1_count),
    .analyzer_enable(analyzer_enable),
    .analyzer_clear(analyzer_clear),
    .f0_result(f0_result),
    .f1_result(f1_result),
    .dominant(dominant),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .busy(busy),
    .overrun(overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_k is the offset within the current measurement sequence:
  // 0 idle, 1 clear, 2..W+1 enabled window, then settle, CAP = capture.
  int          m_k;
  bit          m_ok = 0;
  logic [31:0] m_r0, m_r1;
  logic [1:0]  m_dom;
  bit          m_rv, m_ovr;

  function automatic logic [1:0] dom_of(input logic [31:0] a, input logic [31:0] b);
    if (a > b && a >= MC) return 2'b01;
    if (b > a && b >= MC) return 2'b10;
    return 2'b00;
  endfunction

  always @(posedge clock) begin
    if (!reset) begin
      m_k = 0; m_r0 = 0; m_r1 = 0; m_dom = 0; m_rv = 0; m_ovr = 0; m_ok = 1;
    end else if (m_ok && !abort) begin
      if (m_k == CAP) begin
        m_r0 = f0_count;
        m_r1 = f1_count;
        m_dom = dom_of(f0_count, f1_count);
        if (m_rv && !result_ready) m_ovr = 1;
        m_rv = 1;
        m_k = continuous ? 1 : 0;
      end else begin
        if (m_rv && result_ready) m_rv = 0;
        if (m_k == 0) begin
          if (start) begin
            m_k = 1;
            m_ovr = 0;
          end
        end else begin
          m_k = m_k + 1;
        end
      end
    end else if (m_ok && abort) begin
      m_k = 0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (m_ok) begin
      check("m_enable", 32'(analyzer_enable), 32'(m_k >= 2 && m_k <= W + 1));
      check("m_clear", 32'(analyzer_clear), 32'(m_k == 1));
      check("m_busy", 32'(busy), 32'(m_k != 0));
      check("m_valid", 32'(result_valid), 32'(m_rv));
      check("m_overrun", 32'(overrun), 32'(m_ovr));
      check("m_dominant", 32'(dominant), 32'(m_dom));
      check("m_f0_result", f0_result, m_r0);
      check("m_f1_result", f1_result, m_r1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Single window with ready held high; checks the result at cycle CAP+1.
  task automatic run_shot(input logic [31:0] a, input logic [31:0] b, input logic [1:0] exp_dom);
    f0_count = a; f1_count = b; start = 1'b1;
    tick();
    start = 1'b0;
    tick_n(CAP - 1);
    check("shot_busy_cap", 32'(busy), 32'd1);
    tick();
    check("shot_valid", 32'(result_valid), 32'd1);
    check("shot_dom", 32'(dominant), 32'(exp_dom));
    check("shot_f0", f0_result, a);
    check("shot_f1", f1_result, b);
    tick();
    check("shot_valid_drop", 32'(result_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; continuous = 1'b0; abort = 1'b0;
    f0_count = 0; f1_count = 0; result_ready = 1'b0;
    tick_n(3);
    reset = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_f0", f0_result, 32'd0);
    check("rst_dom", 32'(dominant), 32'd0);
    tick_n(2);

    // Single shot with precise cycle timing.
    result_ready = 1'b1; f0_count = 900; f1_count = 1100; start = 1'b1;
    tick();                                   // cycle 1
    start = 1'b0;
    check("ss_clear_c1", 32'(analyzer_clear), 32'd1);
    check("ss_en_c1", 32'(analyzer_enable), 32'd0);
    tick();                                   // cycle 2
    check("ss_en_c2", 32'(analyzer_enable), 32'd1);
    tick_n(99);                               // cycle 101
    check("ss_en_c101", 32'(analyzer_enable), 32'd1);
    tick();                                   // cycle 102
    check("ss_en_c102", 32'(analyzer_enable), 32'd0);
    check("ss_busy_c102", 32'(busy), 32'd1);
    tick_n(2);                                // cycle 104
    check("ss_valid_c104", 32'(result_valid), 32'd0);
    tick();                                   // cycle 105
    check("ss_valid_c105", 32'(result_valid), 32'd1);
    check("ss_f0", f0_result, 32'd900);
    check("ss_f1", f1_result, 32'd1100);
    check("ss_dom", 32'(dominant), 32'd2);
    check("ss_idle_c105", 32'(busy), 32'd0);
    tick();                                   // cycle 106
    check("ss_valid_c106", 32'(result_valid), 32'd0);

    // Ties and floor.
    run_shot(32'd500, 32'd500, 2'b00);
    run_shot(32'd0, 32'd0, 2'b00);
    run_shot(32'd1, 32'd0, 2'b01);

    // Continuous, ready low: second capture overwrites and flags overrun.
    result_ready = 1'b0; continuous = 1'b1; f0_count = 10; f1_count = 20; start = 1'b1;
    tick();                                   // cycle 1
    start = 1'b0;
    tick_n(104);                              // cycle 105
    check("ct_valid1", 32'(result_valid), 32'd1);
    check("ct_f0_1", f0_result, 32'd10);
    check("ct_clear2", 32'(analyzer_clear), 32'd1);
    f0_count = 30; f1_count = 5;
    tick_n(45);                               // cycle 150, inside second window
    continuous = 1'b0;
    tick_n(59);                               // cycle 209
    check("ct_f0_2", f0_result, 32'd30);
    check("ct_dom_2", 32'(dominant), 32'd1);
    check("ct_valid2", 32'(result_valid), 32'd1);
    check("ct_overrun", 32'(overrun), 32'd1);
    check("ct_idle", 32'(busy), 32'd0);
    result_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("ct_ovr_clear", 32'(overrun), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ct_abort_idle", 32'(busy), 32'd0);
    tick();

    // Abort mid-window keeps previous results.
    result_ready = 1'b0;
    run_shot_hold(32'd7, 32'd3);
    f0_count = 100; f1_count = 200; start = 1'b1;
    tick();                                   // cycle 1
    start = 1'b0;
    tick_n(51);                               // cycle 52, window count 50
    check("ab_en_before", 32'(analyzer_enable), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_en", 32'(analyzer_enable), 32'd0);
    check("ab_valid", 32'(result_valid), 32'd1);
    check("ab_f0", f0_result, 32'd7);
    tick_n(80);
    check("ab_no_cap_f1", f1_result, 32'd3);
    check("ab_no_cap_valid", 32'(result_valid), 32'd1);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("ab_prio", 32'(busy), 32'd0);

    // Capture coincident with a completed handshake.
    f0_count = 40; f1_count = 41; start = 1'b1;
    tick();                                   // cycle 1
    start = 1'b0;
    tick_n(103);                              // cycle 104 (capture)
    result_ready = 1'b1;
    tick();                                   // cycle 105
    check("hs_valid", 32'(result_valid), 32'd1);
    check("hs_f0", f0_result, 32'd40);
    check("hs_dom", 32'(dominant), 32'd2);
    check("hs_overrun", 32'(overrun), 32'd0);
    tick();
    check("hs_drop", 32'(result_valid), 32'd0);

    // Reset mid-window, with start presented during reset.
    f0_count = 55; f1_count = 66; start = 1'b1;
    tick();
    start = 1'b0;
    tick_n(29);
    reset = 1'b0; start = 1'b1;
    tick();
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_en", 32'(analyzer_enable), 32'd0);
    check("mr_f1", f1_result, 32'd0);
    check("mr_dom", 32'(dominant), 32'd0);
    reset = 1'b1; start = 1'b0;
    tick();
    check("mr_start_ignored", 32'(busy), 32'd0);
    tick_n(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Single window with ready low, leaving the result pending.
  task automatic run_shot_hold(input logic [31:0] a, input logic [31:0] b);
    f0_count = a; f1_count = b; start = 1'b1;
    tick();
    start = 1'b0;
    tick_n(CAP);
    check("hold_valid", 32'(result_valid), 32'd1);
    check("hold_f0", f0_result, a);
    tick();
  endtask

endmodule
